// File: rtl/machina_pkg.sv
// Shared widths and handshake convention for the machina datapath blocks.
// Handshake: a transfer happens in a cycle where stb & rdy are both high.
// Framing: a vector is a contiguous run of asserted stb; the first stb-low
// cycle marks the end of the vector.
package machina_pkg;

  localparam int unsigned DEF_ARGW  = 16;
  localparam int unsigned DEF_WGTW  = 16;
  localparam int unsigned DEF_RESW  = 32;
  localparam int unsigned DEF_ADDRW = 6;

endpackage

// File: rtl/weight_ram.sv
// Synchronous RAM with one write port and one registered read port.
module weight_ram
  import machina_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WGTW,
  parameter int unsigned AW    = DEF_ADDRW
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_adr,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_adr,
  output logic [WIDTH-1:0] rd_dat
);

  localparam int unsigned DEPTH = 2 ** AW;

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port and registered read port; contents are never cleared.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_adr] <= wr_dat;
    end
    if (rd_en) begin
      rd_dat <= mem[rd_adr];
    end
  end

endmodule

// File: rtl/weight_multiply.sv
// Multiplies each element of an input vector by a per-position signed weight
// and streams the full-width signed products to the accumulate stage.
module weight_multiply
  import machina_pkg::*;
#(
  parameter int unsigned ARGW  = DEF_ARGW,
  parameter int unsigned WGTW  = DEF_WGTW,
  parameter int unsigned RESW  = DEF_RESW,
  parameter int unsigned ADDRW = DEF_ADDRW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arg_stb,
  input  logic [ARGW-1:0]  arg_dat,
  output logic             arg_rdy,
  output logic             res_stb,
  output logic [RESW-1:0]  res_dat,
  input  logic             res_rdy,
  input  logic             wgt_stb,
  input  logic [ADDRW-1:0] wgt_adr,
  input  logic [WGTW-1:0]  wgt_dat,
  output logic             wgt_rdy
);

  logic                         en;
  logic                         v0;
  logic [ADDRW-1:0]             idx;
  logic signed [ARGW-1:0]       arg_reg;
  logic [WGTW-1:0]              wgt_rd;
  logic signed [ARGW+WGTW-1:0]  prod;
  logic                         wgt_we;

  // Stalls freeze the whole pipeline so a vector never gets a mid-run bubble.
  assign en      = ~res_stb | res_rdy;
  assign arg_rdy = en;

  // Weight writes only while nothing is in flight, so no read/write conflict.
  assign wgt_rdy = ~arg_stb & ~v0 & ~res_stb;
  assign wgt_we  = wgt_stb & wgt_rdy;

  // Full-precision signed product; RESW >= ARGW+WGTW keeps the extreme case exact.
  assign prod = $signed(arg_reg) * $signed(wgt_rd);

  weight_ram #(
    .WIDTH (WGTW),
    .AW    (ADDRW)
  ) u_weight_ram (
    .clk    (clk),
    .wr_en  (wgt_we),
    .wr_adr (wgt_adr),
    .wr_dat (wgt_dat),
    .rd_en  (en),
    .rd_adr (idx),
    .rd_dat (wgt_rd)
  );

  // Element index: restarts on every stb-low cycle, wraps modulo RAM depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
    end else if (!arg_stb) begin
      idx <= '0;
    end else if (en) begin
      idx <= idx + ADDRW'(1);
    end
  end

  // Stage 0: capture the element alongside the weight read.
  always_ff @(posedge clk) begin
    if (rst) begin
      v0      <= 1'b0;
      arg_reg <= '0;
    end else if (en) begin
      v0 <= arg_stb;
      if (arg_stb) begin
        arg_reg <= arg_dat;
      end
    end
  end

  // Stage 1: register the sign-extended product and its valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_stb <= 1'b0;
      res_dat <= '0;
    end else if (en) begin
      res_stb <= v0;
      res_dat <= RESW'(prod);
    end
  end

endmodule

// File: doc/weight_multiply.md
Name: weight_multiply

Overview:
- Upstream neighbour of the accumulate stage. Multiplies each element of an incoming input vector by a per-position signed weight held in an internal weight RAM.
- Emits the signed full-width products as a stream that the accumulate stage consumes directly. Accumulate's `res_dat` is therefore a dot product.
- Framing is the same burst convention: a vector is a contiguous run of asserted strobe. The end of the vector is the first cycle with strobe low.

Parameters:
- ARGW, 16, input element width (signed two's complement).
- WGTW, 16, weight width (signed).
- RESW, 32, product width; must be >= ARGW+WGTW; product is sign-extended to RESW.
- ADDRW, 6, weight RAM address width; depth = 2**ADDRW; maximum vector length.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- arg_stb  in  1  input element valid; held high for the whole vector.
- arg_dat  in  ARGW  input element.
- arg_rdy  out  1  input element accepted when arg_stb & arg_rdy.
- res_stb  out  1  product valid.
- res_dat  out  RESW  signed product.
- res_rdy  in  1  downstream ready.
- wgt_stb  in  1  weight write request.
- wgt_adr  in  ADDRW  weight RAM address.
- wgt_dat  in  WGTW  weight value.
- wgt_rdy  out  1  weight write accepted when wgt_stb & wgt_rdy.

Behaviour:
- Reset: res_stb=0, res_dat=0, index counter=0, all pipeline valids=0. The weight RAM is not cleared and keeps its contents across rst.
- Pipeline enable: en = ~res_stb | res_rdy. arg_rdy = en (combinational).
- Stage 0, on arg_stb & en:
  - register arg_dat;
  - synchronous RAM read at idx;
  - v0 <= 1.
- Stage 0, on ~arg_stb & en: v0 <= 0.
- Stage 1, on en:
  - product = signed(arg_reg) * signed(wgt_rd), sign-extended to RESW;
  - res_dat <= product, res_stb <= v0.
- When en=0 the whole pipeline freezes and res_stb/res_dat hold.
- Latency: 2 cycles from accept to res_stb when res_rdy is held high. Throughput: 1 product per cycle.
- Index counter (idx):
  - increments on each accepted element;
  - forced to 0 in any cycle where arg_stb=0;
  - frozen while arg_stb=1 & arg_rdy=0.
- Framing guarantee:
  - a contiguous accepted input run produces a contiguous res_stb run of equal length;
  - no bubbles are ever inserted mid-vector, because stalls freeze the pipeline rather than drain it;
  - the input gap propagates as a res_stb-low cycle, which is the accumulate end-of-vector marker.
- Wrap-around: if a vector exceeds 2**ADDRW elements, idx wraps to 0 modulo depth. No error is flagged; this is documented as caller misuse.
- Weight writes:
  - wgt_rdy = ~arg_stb & ~v0 & ~res_stb, i.e. only while the datapath is idle;
  - an accepted write updates RAM[wgt_adr] at the next clock edge;
  - a write in cycle N is visible to a vector whose first element is accepted in cycle N+1 or later.
- Simultaneous arg_stb & wgt_stb: the argument path wins, wgt_rdy=0 and the write waits. A read-during-write conflict is therefore impossible.
- Reset mid-vector: in-flight products are discarded and idx returns to 0. The next arg_stb starts a fresh vector at index 0.
- Arithmetic edge: (-2**(ARGW-1))*(-2**(WGTW-1)) = +2**(ARGW+WGTW-2), which must be representable. This is guaranteed by RESW >= ARGW+WGTW.

Decomposition:
- Shared package (machina_pkg): the handshake convention note, default widths ARGW/WGTW/RESW, and the ADDRW default shared with the accumulate and neuron top level.
- Sub-module `weight_ram`: single-port-write / single-port-read synchronous RAM, parameterised by width and depth, with a read enable tied to en. It is reused by later layer blocks.
- The multiply, index counter and handshake logic stay in weight_multiply.

Test Plan:
- Load weights [3,-2,5] at addresses 0..2, then a vector [4,7,-1] with res_rdy=1 -> res_stb high for exactly 3 cycles starting 2 cycles after the first accept; res_dat = 12, -14, -5. res_stb is low the following cycle.
- Same vector with res_rdy=0 held for 4 cycles after the second product appears -> res_stb stays high, res_dat holds -14, arg_rdy=0, and no element is lost or duplicated. Output sequence is still 12, -14, -5.
- Back-to-back vectors [1,1] and [2] separated by one idle arg_stb cycle, weights [3,-2] -> products 3,-2, then a one-cycle res_stb gap, then 6 (idx restarted at 0). With accumulate attached, its results are 1 then 6.
- wgt_stb asserted together with arg_stb -> wgt_rdy=0 until the pipeline drains. The write then lands, and the next vector uses the new weight.
- Extremes with ARGW=WGTW=16: arg=-32768, wgt=-32768 -> res_dat=1073741824. arg=32767, wgt=-32768 -> res_dat=-1073709056.
- rst asserted for 1 cycle while a 3-element vector is in flight -> res_stb=0 the next cycle and res_dat=0. Weights are retained: a subsequent vector [1] yields product 3.
